// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared encodings for the IF/LS memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Counter must hold MEM_LAT-1; the width never drops below one bit.
    function automatic int cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Two-input round-robin pick; on conflict the non-last owner wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_sel,
    output logic any
);

    assign gnt_sel = req1 & (~req0 | (last == OWN_IF));
    assign any     = req0 | req1;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares the single memory port between fetch and load/store.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_if_gnt;
    logic              r_ls_gnt;
    logic              r_if_rvalid;
    logic              r_ls_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              w_sel;
    logic              w_any;
    logic              w_access;

    rr_arbiter2 u_rr (
        .req0    (if_req),
        .req1    (ls_req),
        .last    (r_last_owner),
        .gnt_sel (w_sel),
        .any     (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_if_gnt     <= 1'b0;
            r_ls_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_ls_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
        end else begin
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state  <= ST_ACCESS;
                        r_owner  <= w_sel;
                        r_addr   <= w_sel ? ls_addr : if_addr;
                        r_we     <= w_sel & ls_we;
                        r_wdata  <= w_sel ? ls_wdata : '0;
                        r_cnt    <= c_cnt_load;
                        r_if_gnt <= ~w_sel;
                        r_ls_gnt <= w_sel;
                    end
                end
                ST_ACCESS: begin
                    // Read data is only guaranteed in the final access cycle.
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        if (r_owner == OWN_LS) begin
                            r_ls_rdata  <= r_we ? '0 : mem_rdata;
                            r_ls_rvalid <= 1'b1;
                        end else begin
                            r_if_rdata  <= mem_rdata;
                            r_if_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_RESP: begin
                    r_last_owner <= r_owner;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_access  = (r_state == ST_ACCESS);
    assign mem_en    = w_access;
    assign mem_we    = w_access & r_we;
    assign mem_sel   = w_access & r_owner;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign if_gnt    = r_if_gnt;
    assign ls_gnt    = r_ls_gnt;
    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;

endmodule
`default_nettype wire
